// File: rtl/mac_unit_pkg.sv
// mac_unit_pkg: shared constants and types for the N-lane dot-product engine.
//   MAC_WI : default weight/activation element width
//   MAC_N  : default lane count (power of two, >= 2)
//   MAC_WN : adder-tree depth, log2(MAC_N)
//   MAC_PW : signed lane-product width, 2*(MAC_WI+1)
//   MAC_WO : signed result width, MAC_PW + MAC_WN
package mac_unit_pkg;

    localparam int MAC_WI = 8;
    localparam int MAC_N  = 16;
    localparam int MAC_WN = $clog2(MAC_N);
    localparam int MAC_PW = 2 * (MAC_WI + 1);
    localparam int MAC_WO = MAC_PW + MAC_WN;

    typedef logic signed [MAC_PW-1:0] mac_prod_t;
    typedef logic signed [MAC_WO-1:0] mac_acc_t;

endpackage

// File: rtl/mac_adder_tree.sv
// mac_adder_tree: registered binary reduction of N signed PW-bit inputs into
// one WO-bit sum, one tree level per clock, valid carried alongside.
// Ports:
//   clk     : clock
//   rst     : asynchronous active-high reset, clears all sums and valids
//   i_vld   : input beat valid
//   i_data  : N packed signed PW-bit operands, lane k at [k*PW +: PW]
//   o_sum   : signed WO-bit sum, valid when o_vld is high
//   o_vld   : valid of o_sum
module mac_adder_tree
    import mac_unit_pkg::*;
#(
    parameter int N  = MAC_N,
    parameter int PW = MAC_PW,
    parameter int WO = MAC_WO,
    localparam int WN = $clog2(N)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_vld,
    input  logic [N*PW-1:0]      i_data,
    output logic signed [WO-1:0] o_sum,
    output logic                 o_vld
);

    // Heap layout: node 1 is the root, node i sums nodes 2i and 2i+1.
    // Indices N..2N-1 are the leaves (the inputs), 1..N-1 are registers.
    logic signed [WO-1:0] r_node [1:N-1];
    logic signed [WO-1:0] w_kid  [2:2*N-1];
    logic [WN-1:0]        r_vld;
    logic [WN:0]          w_vld;

    // w_vld[l] is the valid of the operands feeding tree level l+1.
    assign w_vld = {r_vld, i_vld};

    // Level of node i counted from the leaves: root sits at level WN.
    function automatic int node_lvl(input int i);
        int l;
        l = WN;
        for (int k = i; k > 1; k = k >> 1) begin
            l = l - 1;
        end
        return l;
    endfunction

    always_comb begin
        for (int c = 2; c < 2 * N; c++) begin
            if (c >= N) begin
                w_kid[c] = {{(WO-PW){i_data[(c-N)*PW + PW - 1]}}, i_data[(c-N)*PW +: PW]};
            end else begin
                w_kid[c] = r_node[c];
            end
        end
    end

    // Each level only loads when the beat below it is valid, so idle cycles
    // leave every partial sum untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 1; i < N; i++) begin
                r_node[i] <= '0;
            end
        end else begin
            r_vld <= w_vld[WN-1:0];
            for (int i = 1; i < N; i++) begin
                if (w_vld[node_lvl(i) - 1]) begin
                    r_node[i] <= w_kid[2*i] + w_kid[2*i+1];
                end
            end
        end
    end

    assign o_sum = r_node[1];
    assign o_vld = w_vld[WN];

endmodule

// File: rtl/mac_unit.sv
// mac_unit: pipelined N-lane dot product. Each valid beat multiplies signed
// weights by unsigned activations lane-wise and sums all products exactly.
// Latency is 1+WN cycles from the sampling edge, one beat per clock.
// Ports:
//   clk   : clock
//   rstn  : asynchronous reset, active HIGH despite the name
//   vld_i : beat valid; win/din sampled when high
//   win   : N packed signed WI-bit weights, lane k at [k*WI +: WI]
//   din   : N packed unsigned WI-bit activations, lane k at [k*WI +: WI]
//   acc_o : signed WO-bit dot product, held between results
//   vld_o : one-cycle pulse per accepted beat
module mac_unit
    import mac_unit_pkg::*;
#(
    parameter int WI = MAC_WI,
    parameter int N  = MAC_N,
    localparam int WN = $clog2(N),
    localparam int PW = 2 * (WI + 1),
    localparam int WO = PW + WN
)(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 vld_i,
    input  logic [N*WI-1:0]      win,
    input  logic [N*WI-1:0]      din,
    output logic signed [WO-1:0] acc_o,
    output logic                 vld_o
);

    function automatic logic signed [WI:0] ext_w(input logic [WI-1:0] v);
        return {v[WI-1], v};
    endfunction

    function automatic logic signed [WI:0] ext_d(input logic [WI-1:0] v);
        return {1'b0, v};
    endfunction

    logic [N*PW-1:0]      w_prod;
    logic [N*PW-1:0]      r_prod_p0;
    logic                 r_vld_p0;
    logic signed [WO-1:0] w_tree_sum;
    logic                 w_tree_vld;
    logic signed [WO-1:0] r_acc;
    logic                 r_vld_out;

    // Both operands are WI+1 signed, so the PW-wide product is exact.
    always_comb begin
        logic signed [PW-1:0] v_p;
        w_prod = '0;
        v_p    = '0;
        for (int k = 0; k < N; k++) begin
            v_p = ext_w(win[k*WI +: WI]) * ext_d(din[k*WI +: WI]);
            w_prod[k*PW +: PW] = v_p;
        end
    end

    // ---- stage 0: lane products ----
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_vld_p0  <= 1'b0;
            r_prod_p0 <= '0;
        end else begin
            r_vld_p0 <= vld_i;
            if (vld_i) begin
                r_prod_p0 <= w_prod;
            end
        end
    end

    // ---- stages 1..WN: adder tree ----
    mac_adder_tree #(
        .N  (N),
        .PW (PW),
        .WO (WO)
    ) u_tree (
        .clk    (clk),
        .rst    (rstn),
        .i_vld  (r_vld_p0),
        .i_data (r_prod_p0),
        .o_sum  (w_tree_sum),
        .o_vld  (w_tree_vld)
    );

    // ---- output register: holds the last result while idle ----
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_vld_out <= 1'b0;
            r_acc     <= '0;
        end else begin
            r_vld_out <= w_tree_vld;
            if (w_tree_vld) begin
                r_acc <= w_tree_sum;
            end
        end
    end

    assign acc_o = r_acc;
    assign vld_o = r_vld_out;

endmodule

// File: tb/tb_mac_unit.sv
module tb_mac_unit;
    import mac_unit_pkg::*;

    localparam int WI  = 8;
    localparam int N   = 16;
    localparam int WO  = 22;
    localparam int LAT = 6;   // from drive time (just after edge c) to result visible after edge c+6

    logic            clk;
    logic            rstn;
    logic            vld_i;
    logic [N*WI-1:0] win;
    logic [N*WI-1:0] din;
    mac_acc_t        acc_o;
    logic            vld_o;

    mac_unit dut (
        .clk   (clk),
        .rstn  (rstn),
        .vld_i (vld_i),
        .win   (win),
        .din   (din),
        .acc_o (acc_o),
        .vld_o (vld_o)
    );

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   last_exp = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // Reference: plain integer dot product of signed weights and unsigned activations.
    function automatic int dot(input logic [N*WI-1:0] w, input logic [N*WI-1:0] d);
        int s;
        logic signed [WI-1:0] ws;
        logic [WI-1:0] du;
        int wi_v;
        int di_v;
        s = 0;
        for (int k = 0; k < N; k++) begin
            ws   = w[k*WI +: WI];
            du   = d[k*WI +: WI];
            wi_v = ws;
            di_v = du;
            s    = s + wi_v * di_v;
        end
        return s;
    endfunction

    function automatic logic [N*WI-1:0] fill(input logic [WI-1:0] v);
        logic [N*WI-1:0] r;
        for (int k = 0; k < N; k++) r[k*WI +: WI] = v;
        return r;
    endfunction

    function automatic logic [N*WI-1:0] rnd_vec();
        logic [N*WI-1:0] r;
        for (int k = 0; k < N; k++) r[k*WI +: WI] = WI'($urandom);
        return r;
    endfunction

    task automatic beat(input logic [N*WI-1:0] w, input logic [N*WI-1:0] d, input int exp_val);
        exp_t e;
        @(posedge clk);
        #1;
        vld_i = 1'b1;
        win   = w;
        din   = d;
        e.val = exp_val;
        e.due = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            vld_i = 1'b0;
            win   = rnd_vec();
            din   = rnd_vec();
        end
    endtask

    // Monitor: every vld_o pulse must match the oldest outstanding beat, on time.
    always @(negedge clk) begin
        exp_t e;
        if (vld_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_vld_o", 1, 0);
            end else begin
                e = sb.pop_front();
                check("acc_o", int'(acc_o), e.val);
                check("latency_cycle", cyc, e.due);
                last_exp = e.val;
            end
        end
    end

    initial begin
        logic [N*WI-1:0] ramp;
        logic [N*WI-1:0] w;
        logic [N*WI-1:0] d;
        exp_t e;
        int guard;

        for (int k = 0; k < N; k++) ramp[k*WI +: WI] = WI'(k);

        rstn  = 1'b1;
        vld_i = 1'b0;
        win   = '0;
        din   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_acc_o", int'(acc_o), 0);
        check("reset_vld_o", int'(vld_o), 0);
        rstn = 1'b0;
        idle(2);

        // Ramp
        beat(fill(8'h01), ramp, 120);
        idle(8);

        // Signed weights and extremes
        beat(fill(8'hFF), fill(8'hFF), -4080);
        beat(fill(8'h80), fill(8'hFF), -522240);
        beat(fill(8'h7F), fill(8'hFF), 518160);
        idle(8);

        // Streaming with a one-cycle gap
        beat(fill(8'h01), fill(8'h01), 16);
        beat(fill(8'h02), fill(8'h01), 32);
        beat(fill(8'h03), fill(8'h01), 48);
        beat(fill(8'h04), fill(8'h01), 64);
        idle(1);
        beat(fill(8'h01), fill(8'h01), 16);
        idle(8);

        // Reset with a beat in flight: no pulse may come out for it
        beat(fill(8'h01), ramp, 120);
        idle(2);
        rstn = 1'b1;
        sb.delete();
        #1;
        check("midreset_acc_o", int'(acc_o), 0);
        check("midreset_vld_o", int'(vld_o), 0);
        idle(2);
        rstn = 1'b0;
        idle(1);
        beat(fill(8'h01), ramp, 120);
        idle(8);

        // Hold: idle inputs must not disturb the last result
        for (int i = 0; i < 10; i++) begin
            idle(1);
            @(negedge clk);
            check("hold_acc_o", int'(acc_o), last_exp);
            check("hold_vld_o", int'(vld_o), 0);
        end

        // Random traffic with random bubbles
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) != 0) begin
                w = rnd_vec();
                d = rnd_vec();
                beat(w, d, dot(w, d));
            end else begin
                idle(1);
            end
        end
        idle(1);

        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        check("drain_pending", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
